writeback_stage: RTL and testbench

// - Final RV32I pipeline stage, fed directly by the memory stage's pipeline register outputs.
// - Drives the load read address into data memory and formats the returned load word.
// - Selects the result (ALU / load / link) and writes it into the 32x32 integer register file it owns.
// - Serves decode reads with write-through bypass, holds a last-write record for hazard forwarding,
//   and keeps a 64-bit retired-instruction counter.

---
 rtl/writeback_stage.sv | 75 +++++++
 tb/tb_writeback_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: RV32I writeback with load formatting, register file, bypass, last-write record, retire counter
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic            reg_file_en_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] load_adres_o,
    input  logic [XLEN-1:0] load_mem_data_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            last_en_o,
    output logic [4:0]      last_rd_o,
    output logic [XLEN-1:0] last_data_o,
    output logic [63:0]     retired_o
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            is_load;
    logic            is_link;
    logic [XLEN-1:0] w;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] regs [NUM_REGS];

    assign opc     = instr_i[6:0];
    assign f3      = instr_i[14:12];
    assign rd      = instr_i[11:7];
    assign is_load = opc == 7'b0000011;
    assign is_link = opc == 7'b1101111 || opc == 7'b1100111;
    assign w       = load_mem_data_i;

    // decode, load formatting, result selection and same-cycle bypass reads
    always_comb begin
        load_adres_o = is_load ? alu_out_i : '0;
        load_val = f3 == 3'b000 ? {{24{w[7]}}, w[7:0]} :
                   f3 == 3'b001 ? {{16{w[15]}}, w[15:0]} :
                   f3 == 3'b010 ? w :
                   f3 == 3'b100 ? {24'h0, w[7:0]} :
                   f3 == 3'b101 ? {16'h0, w[15:0]} : '0;
        wb_en_o   = reg_file_en_i && rd != 5'd0;
        wb_rd_o   = rd;
        wb_data_o = is_load ? load_val : is_link ? pc_i + 32'd4 : alu_out_i;
        rs1_data_o = rs1_addr_i == 5'd0 ? '0 :
                     (wb_en_o && rs1_addr_i == rd) ? wb_data_o : regs[rs1_addr_i];
        rs2_data_o = rs2_addr_i == 5'd0 ? '0 :
                     (wb_en_o && rs2_addr_i == rd) ? wb_data_o : regs[rs2_addr_i];
    end

    // register file write, last-write record and retire counter; reset wins over all
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            last_en_o   <= 1'b0;
            last_rd_o   <= 5'd0;
            last_data_o <= '0;
            retired_o   <= 64'd0;
        end else begin
            if (wb_en_o) regs[rd] <= wb_data_o;
            last_en_o   <= wb_en_o;
            last_rd_o   <= wb_rd_o;
            last_data_o <= wb_data_o;
            if (instr_i != 32'h0) retired_o <= retired_o + 64'd1;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage
module tb_writeback_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        reg_file_en_i;
    logic [31:0] alu_out_i;
    logic [31:0] pc_i;
    logic [31:0] load_adres_o;
    logic [31:0] load_mem_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        last_en_o;
    logic [4:0]  last_rd_o;
    logic [31:0] last_data_o;
    logic [63:0] retired_o;
    int n_cmp = 0;
    int n_bad = 0;

    writeback_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .reg_file_en_i(reg_file_en_i),
        .alu_out_i(alu_out_i), .pc_i(pc_i), .load_adres_o(load_adres_o),
        .load_mem_data_i(load_mem_data_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .last_en_o(last_en_o), .last_rd_o(last_rd_o),
        .last_data_o(last_data_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic en, input logic [31:0] alu);
        instr_i = ins;
        reg_file_en_i = en;
        alu_out_i = alu;
        #1;
    endtask

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JAL    = 7'b1101111;

    initial begin
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
        logic [31:0] lexp [5] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF8081, 32'h00008081, 32'h0};
        rst_i = 1'b1; instr_i = '0; reg_file_en_i = 1'b0; alu_out_i = '0; pc_i = '0;
        load_mem_data_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst_retired", retired_o, 64'd0);
        check("rst_last_en", {63'd0, last_en_o}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            #1;
            check($sformatf("rst_x%0d", i), {32'd0, rs1_data_o}, 64'd0);
        end

        rs1_addr_i = 5'd5;
        drive(mk(OP_IMM, 3'b000, 5'd5), 1'b1, 32'hDEAD_BEEF);
        check("addi_bypass", {32'd0, rs1_data_o}, 64'hDEADBEEF);
        check("addi_wb_en", {63'd0, wb_en_o}, 64'd1);
        check("addi_wb_rd", {59'd0, wb_rd_o}, 64'd5);
        check("addi_adres", {32'd0, load_adres_o}, 64'd0);
        tick();
        drive(32'h0, 1'b0, 32'h0);
        check("addi_reg", {32'd0, rs1_data_o}, 64'hDEADBEEF);
        check("addi_last_rd", {59'd0, last_rd_o}, 64'd5);
        check("addi_last_data", {32'd0, last_data_o}, 64'hDEADBEEF);
        check("addi_last_en", {63'd0, last_en_o}, 64'd1);

        load_mem_data_i = 32'h0000_8081;
        for (int i = 0; i < 5; i++) begin
            drive(mk(LOAD, f3s[i], 5'(10 + i)), 1'b1, 32'h0000_0040 + 32'(i));
            check($sformatf("load_f3_%0d", f3s[i]), {32'd0, wb_data_o}, {32'd0, lexp[i]});
            check($sformatf("load_adres_%0d", i), {32'd0, load_adres_o}, {32'd0, 32'h40 + 32'(i)});
            tick();
        end
        drive(32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            rs2_addr_i = 5'(10 + i);
            #1;
            check($sformatf("load_reg_x%0d", 10 + i), {32'd0, rs2_data_o}, {32'd0, lexp[i]});
        end

        drive(mk(OP_IMM, 3'b000, 5'd1), 1'b1, 32'h1111);
        tick();
        pc_i = 32'hFFFF_FFFC;
        drive(mk(JAL, 3'b000, 5'd1), 1'b1, 32'h55);
        check("jal_wb_data", {32'd0, wb_data_o}, 64'd0);
        tick();
        drive(32'h0, 1'b0, 32'h0);
        rs1_addr_i = 5'd1;
        #1;
        check("jal_x1", {32'd0, rs1_data_o}, 64'd0);

        rs1_addr_i = 5'd0;
        drive(mk(OP_IMM, 3'b000, 5'd0), 1'b1, 32'h1234);
        check("x0_wb_en", {63'd0, wb_en_o}, 64'd0);
        check("x0_read", {32'd0, rs1_data_o}, 64'd0);
        tick();
        drive(32'h0, 1'b0, 32'h0);
        rs2_addr_i = 5'd0;
        #1;
        check("x0_after", {32'd0, rs2_data_o}, 64'd0);
        check("x0_last_en", {63'd0, last_en_o}, 64'd0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("re_rst_retired", retired_o, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(mk(OP_IMM, 3'b000, 5'd8), i == 0, 32'h88 + 32'(i));
            tick();
        end
        drive(32'h0, 1'b0, 32'h0);
        tick();
        check("retired_3", retired_o, 64'd3);
        rs1_addr_i = 5'd8;
        #1;
        check("x8_before_rst", {32'd0, rs1_data_o}, 64'h88);
        rst_i = 1'b1;
        drive(mk(OP_IMM, 3'b000, 5'd7), 1'b1, 32'h77);
        tick();
        rst_i = 1'b0;
        drive(32'h0, 1'b0, 32'h0);
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd8;
        #1;
        check("rst_retired_0", retired_o, 64'd0);
        check("rst_x7", {32'd0, rs1_data_o}, 64'd0);
        check("rst_x8", {32'd0, rs2_data_o}, 64'd0);
        check("rst_last_en2", {63'd0, last_en_o}, 64'd0);
        check("rst_last_data", {32'd0, last_data_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
